// File: rtl/lcd8080_ctrl.sv
// ---------------------------------------------------------------------------
// lcd8080_ctrl
//
// Host-side controller for an Intel-8080 style parallel LCD bus. The host
// queues command/data transfers into a small FIFO. A timing FSM plays each
// entry out as SETUP -> STROBE -> HOLD. Back-to-back entries keep cs low as
// one continuous burst. A latched hardware-reset request produces a single
// rst-low pulse, but only between transfers, so a transfer in flight is
// never cut short.
//
// Ports
//   pclk, prst       clock (rising edge), synchronous active-low reset
//   in_valid/ready   host push handshake (ready = FIFO not full)
//   in_rs, in_rd     entry type: rs (0 cmd / 1 data), rd (1 read / 0 write)
//   in_data          write payload
//   rd_valid/rd_data one-cycle pulse with the value sampled on a read
//   busy             FIFO non-empty or a transfer/reset in progress
//   hw_rst_req       one-cycle request for an LCD reset pulse
//   blk_en / blk     backlight enable, registered straight through
//   cs rs wr rd rst  8080 bus controls (cs, wr, rd, rst active-low)
//   data_o/data_oe   bus drive value and drive enable
//   data_i           bus sample value
// ---------------------------------------------------------------------------
module lcd8080_ctrl #(
  parameter int DW     = 16,
  parameter int DEPTH  = 16,
  parameter int T_LOW  = 2,
  parameter int T_HIGH = 2,
  parameter int T_RST  = 16
) (
  input  logic          pclk,
  input  logic          prst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_rs,
  input  logic          in_rd,
  input  logic [DW-1:0] in_data,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  input  logic          hw_rst_req,
  input  logic          blk_en,
  output logic          cs,
  output logic          rs,
  output logic          wr,
  output logic          rd,
  output logic          rst,
  output logic          blk,
  output logic [DW-1:0] data_o,
  output logic          data_oe,
  input  logic [DW-1:0] data_i
);

  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW     = $clog2(DEPTH + 1);
  localparam int TMAX_A = (T_LOW > T_HIGH) ? T_LOW : T_HIGH;
  localparam int TMAX   = (T_RST > TMAX_A) ? T_RST : TMAX_A;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int EW     = DW + 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_RESET  = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [NW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;

  // FSM and the entry currently on the bus
  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_tmr;
  logic          r_rst_pend;
  logic          r_cur_rs;
  logic          r_cur_rd;
  logic [DW-1:0] r_cur_data;

  logic          r_rd_valid;
  logic [DW-1:0] r_rd_data;
  logic          r_blk;
  logic          w_in_xfer;
  logic          w_rd_capture;

  assign w_full  = (r_count == NW'(DEPTH));
  assign w_empty = (r_count == '0);
  // A pop in the same cycle does not free a slot for a push offered while full.
  assign w_push  = in_valid && !w_full;
  assign w_head  = r_mem[r_rptr];

  // ------------------------------------------------------------------ FIFO
  always_ff @(posedge pclk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {in_rs, in_rd, in_data};
    end
  end

  always_ff @(posedge pclk) begin
    if (!prst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + NW'(1);
        2'b01:   r_count <= r_count - NW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ------------------------------------------------------------------ FSM state register
  always_ff @(posedge pclk) begin
    if (!prst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_rst_pend) begin
          w_state_nxt = S_RESET;
        end else if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_STROBE;
      end
      S_STROBE: begin
        if (r_tmr == '0) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_tmr == '0) begin
          // A pending reset wins over a burst continuation; it is taken from IDLE.
          if (!r_rst_pend && !w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_SETUP;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_RESET: begin
        if (r_tmr == '0) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------ phase timer
  // Loaded with (length-1) on entry to a timed state, counts down to zero.
  always_ff @(posedge pclk) begin
    if (!prst) begin
      r_tmr <= '0;
    end else if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        S_STROBE: r_tmr <= TW'(T_LOW - 1);
        S_HOLD:   r_tmr <= TW'(T_HIGH - 1);
        S_RESET:  r_tmr <= TW'(T_RST - 1);
        default:  r_tmr <= '0;
      endcase
    end else if (r_tmr != '0) begin
      r_tmr <= r_tmr - TW'(1);
    end
  end

  // ------------------------------------------------------------------ reset request latch
  // Cleared on entry to RESET; requests arriving while RESET runs are dropped
  // so one burst of requests yields exactly one pulse.
  always_ff @(posedge pclk) begin
    if (!prst) begin
      r_rst_pend <= 1'b0;
    end else if (r_state == S_RESET || w_state_nxt == S_RESET) begin
      r_rst_pend <= 1'b0;
    end else if (hw_rst_req) begin
      r_rst_pend <= 1'b1;
    end
  end

  // ------------------------------------------------------------------ current entry
  always_ff @(posedge pclk) begin
    if (!prst) begin
      r_cur_rs   <= 1'b0;
      r_cur_rd   <= 1'b0;
      r_cur_data <= '0;
    end else if (w_pop) begin
      r_cur_rs   <= w_head[EW-1];
      r_cur_rd   <= w_head[EW-2];
      r_cur_data <= w_head[DW-1:0];
    end
  end

  // ------------------------------------------------------------------ read capture
  // Sample on the edge that ends the last STROBE cycle; rd_valid is then high
  // for the first HOLD cycle together with the captured value.
  assign w_rd_capture = (r_state == S_STROBE) && (r_tmr == '0) && r_cur_rd;

  always_ff @(posedge pclk) begin
    if (!prst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_capture;
      if (w_rd_capture) begin
        r_rd_data <= data_i;
      end
    end
  end

  // ------------------------------------------------------------------ backlight
  always_ff @(posedge pclk) begin
    if (!prst) begin
      r_blk <= 1'b0;
    end else begin
      r_blk <= blk_en;
    end
  end

  // ------------------------------------------------------------------ outputs
  assign w_in_xfer = (r_state == S_SETUP) || (r_state == S_STROBE) || (r_state == S_HOLD);

  assign in_ready = !w_full;
  assign busy     = !w_empty || (r_state != S_IDLE);
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign cs       = !w_in_xfer;
  assign rs       = r_cur_rs;
  assign wr       = !((r_state == S_STROBE) && !r_cur_rd);
  assign rd       = !((r_state == S_STROBE) && r_cur_rd);
  assign rst      = (r_state != S_RESET);
  assign blk      = r_blk;
  // data_o keeps the last entry between transfers; only data_oe gates the bus.
  assign data_o   = r_cur_data;
  assign data_oe  = w_in_xfer && !r_cur_rd;

endmodule

// File: tb/tb_lcd8080_ctrl.sv
module tb_lcd8080_ctrl;
  localparam int DW     = 16;
  localparam int DEPTH  = 16;
  localparam int T_LOW  = 2;
  localparam int T_HIGH = 2;
  localparam int T_RST  = 16;
  localparam int XFER   = 1 + T_LOW + T_HIGH;

  logic          pclk = 1'b0;
  logic          prst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_rs = 1'b0;
  logic          in_rd = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          hw_rst_req = 1'b0;
  logic          blk_en = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          in_ready, rd_valid, busy, cs, rs, wr, rd, rst, blk, data_oe;
  logic [DW-1:0] rd_data, data_o;

  always #5 pclk = ~pclk;

  lcd8080_ctrl #(.DW(DW), .DEPTH(DEPTH), .T_LOW(T_LOW), .T_HIGH(T_HIGH), .T_RST(T_RST)) dut (
    .pclk(pclk), .prst(prst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rd(in_rd), .in_data(in_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .hw_rst_req(hw_rst_req), .blk_en(blk_en),
    .cs(cs), .rs(rs), .wr(wr), .rd(rd), .rst(rst), .blk(blk),
    .data_o(data_o), .data_oe(data_oe), .data_i(data_i)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- bus monitor: turns pin activity into transactions
  typedef struct {
    logic          rs;
    logic          rd;
    logic [DW-1:0] data;
    logic          oe;
    logic          stable;
    int            len;
    int            start;
    logic [DW-1:0] din;
  } strobe_t;

  strobe_t       obs_q[$];
  strobe_t       cur;
  int            cs_runs_q[$];
  logic [1:0]    cs_oe_q[$];
  int            rst_len_q[$];
  int            rst_start_q[$];
  logic [DW-1:0] rdv_q[$];
  int            cyc = 0, cs_cnt = 0, st_cnt = 0, rst_cnt = 0, viol = 0;
  logic          oe_and = 1'b1, oe_or = 1'b0;

  always @(negedge pclk) begin
    cyc++;
    if (!prst) begin
      cs_cnt = 0; st_cnt = 0; rst_cnt = 0; oe_and = 1'b1; oe_or = 1'b0;
    end else begin
      if (!cs) begin
        cs_cnt++; oe_and = oe_and & data_oe; oe_or = oe_or | data_oe;
      end else if (cs_cnt > 0) begin
        cs_runs_q.push_back(cs_cnt); cs_oe_q.push_back({oe_and, oe_or});
        cs_cnt = 0; oe_and = 1'b1; oe_or = 1'b0;
      end
      if (!wr && !rd) viol++;
      if (!wr || !rd) begin
        if (cs) viol++;
        if (st_cnt == 0) begin
          cur.rs = rs; cur.rd = !rd; cur.data = data_o; cur.oe = data_oe;
          cur.stable = 1'b1; cur.start = cyc;
        end else if (rs !== cur.rs || data_oe !== cur.oe || (!rd) !== cur.rd ||
                     (cur.oe && data_o !== cur.data)) begin
          cur.stable = 1'b0;
        end
        cur.din = data_i;
        st_cnt++;
      end else if (st_cnt > 0) begin
        cur.len = st_cnt; obs_q.push_back(cur); st_cnt = 0;
      end
      if (!rst) begin
        if (!cs) viol++;
        if (rst_cnt == 0) rst_start_q.push_back(cyc);
        rst_cnt++;
      end else if (rst_cnt > 0) begin
        rst_len_q.push_back(rst_cnt); rst_cnt = 0;
      end
      if (rd_valid) rdv_q.push_back(rd_data);
    end
  end

  task automatic clear_mon();
    obs_q.delete(); cs_runs_q.delete(); cs_oe_q.delete();
    rst_len_q.delete(); rst_start_q.delete(); rdv_q.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  task automatic push(input logic r_s, input logic r_d, input logic [DW-1:0] d, output logic acc);
    in_valid = 1'b1; in_rs = r_s; in_rd = r_d; in_data = d;
    acc = in_ready;
    @(posedge pclk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    do begin @(negedge pclk); k++; end while (busy && k < budget);
    chk({name, "_idle"}, busy, 1'b0);
    repeat (3) @(negedge pclk);
    @(posedge pclk); #1;
  endtask

  task automatic wait_wr(input logic lvl, input int budget, input string name);
    int k;
    k = 0;
    do begin @(negedge pclk); k++; end while (wr !== lvl && k < budget);
    chk(name, wr, lvl);
  endtask

  typedef struct {
    logic          rs;
    logic          rd;
    logic [DW-1:0] data;
    logic [DW-1:0] din;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic    acc;
    int      nacc;
    strobe_t exp_q[$];
    strobe_t e;
    logic [DW-1:0] exp_rdv[$];
    int      sum;
    logic    mod_ok;

    // ---------------- reset state (inputs active during reset must be ignored)
    prst = 1'b0; blk_en = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF;
    tick(3);
    in_valid = 1'b0; blk_en = 1'b0;
    @(negedge pclk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 16'h0);
    chk("rst_cs", cs, 1'b1);
    chk("rst_wr", wr, 1'b1);
    chk("rst_rd", rd, 1'b1);
    chk("rst_rs", rs, 1'b0);
    chk("rst_rst", rst, 1'b1);
    chk("rst_blk", blk, 1'b0);
    chk("rst_data_oe", data_oe, 1'b0);
    chk("rst_data_o", data_o, 16'h0);
    @(posedge pclk); #1;
    prst = 1'b1;
    tick(2);
    chk("post_rst_busy", busy, 1'b0);

    // ---------------- single transfers, table driven
    vecs[0] = '{rs: 1'b0, rd: 1'b0, data: 16'h002C, din: 16'h0000};
    vecs[1] = '{rs: 1'b1, rd: 1'b1, data: 16'h1234, din: 16'hA5C3};
    vecs[2] = '{rs: 1'b1, rd: 1'b0, data: 16'hFFFF, din: 16'h0F0F};
    vecs[3] = '{rs: 1'b0, rd: 1'b1, data: 16'h5555, din: 16'h0000};
    vecs[4] = '{rs: 1'b1, rd: 1'b0, data: 16'h8001, din: 16'hFFFF};
    vecs[5] = '{rs: 1'b0, rd: 1'b1, data: 16'h0000, din: 16'hFFFF};
    for (int i = 0; i < 6; i++) begin
      clear_mon();
      data_i = vecs[i].din;
      push(vecs[i].rs, vecs[i].rd, vecs[i].data, acc);
      chk($sformatf("v%0d_accept", i), acc, 1'b1);
      chk($sformatf("v%0d_busy", i), busy, 1'b1);
      wait_idle(100, $sformatf("v%0d", i));
      chk($sformatf("v%0d_nstrobe", i), obs_q.size(), 1);
      chk($sformatf("v%0d_ncs", i), cs_runs_q.size(), 1);
      chk($sformatf("v%0d_nrdv", i), rdv_q.size(), vecs[i].rd ? 1 : 0);
      if (obs_q.size() > 0) begin
        chk($sformatf("v%0d_rs", i), obs_q[0].rs, vecs[i].rs);
        chk($sformatf("v%0d_dir", i), obs_q[0].rd, vecs[i].rd);
        chk($sformatf("v%0d_len", i), obs_q[0].len, T_LOW);
        chk($sformatf("v%0d_stable", i), obs_q[0].stable, 1'b1);
        if (!vecs[i].rd) chk($sformatf("v%0d_data", i), obs_q[0].data, vecs[i].data);
      end
      if (cs_runs_q.size() > 0) begin
        chk($sformatf("v%0d_cslen", i), cs_runs_q[0], XFER);
        chk($sformatf("v%0d_oe", i), cs_oe_q[0], vecs[i].rd ? 2'b00 : 2'b11);
      end
      if (rdv_q.size() > 0) chk($sformatf("v%0d_rd_data", i), rdv_q[0], vecs[i].din);
    end

    // ---------------- burst of three data writes
    clear_mon();
    push(1'b1, 1'b0, 16'h1111, acc);
    push(1'b1, 1'b0, 16'h2222, acc);
    push(1'b1, 1'b0, 16'h3333, acc);
    wait_idle(200, "burst");
    chk("burst_ncs", cs_runs_q.size(), 1);
    if (cs_runs_q.size() > 0) chk("burst_cslen", cs_runs_q[0], 3 * XFER);
    chk("burst_nstrobe", obs_q.size(), 3);
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      chk($sformatf("burst%0d_data", i), obs_q[i].data, 16'h1111 * (i + 1));
      chk($sformatf("burst%0d_rs", i), obs_q[i].rs, 1'b1);
      chk($sformatf("burst%0d_len", i), obs_q[i].len, T_LOW);
    end

    // ---------------- backlight latency
    blk_en = 1'b1;
    @(negedge pclk);
    chk("blk_before_edge", blk, 1'b0);
    @(posedge pclk); #1;
    chk("blk_after_edge", blk, 1'b1);

    // ---------------- reset pulse from idle; second request during RESET absorbed
    clear_mon();
    hw_rst_req = 1'b1; tick(1); hw_rst_req = 1'b0;
    tick(5);
    hw_rst_req = 1'b1; tick(1); hw_rst_req = 1'b0;
    tick(40);
    chk("hwrst_npulse", rst_len_q.size(), 1);
    if (rst_len_q.size() > 0) chk("hwrst_len", rst_len_q[0], T_RST);
    chk("hwrst_no_xfer", obs_q.size(), 0);

    // ---------------- fill the FIFO while RESET holds the FSM
    clear_mon();
    nacc = 0;
    hw_rst_req = 1'b1; tick(1); hw_rst_req = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      push(i[0], 1'b0, 16'h0100 + 16'(i), acc);
      if (acc) nacc++;
      if (i == DEPTH - 1) chk("full_in_ready", in_ready, 1'b0);
      if (i == DEPTH) chk("full_drop", acc, 1'b0);
    end
    chk("full_naccepted", nacc, DEPTH);
    wait_idle(600, "full");
    chk("full_ntransfers", obs_q.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < obs_q.size(); i++)
      chk($sformatf("full%0d_data", i), obs_q[i].data, 16'h0100 + 16'(i));
    if (rst_len_q.size() > 0) chk("full_rstlen", rst_len_q[0], T_RST);

    // ---------------- reset request during STROBE of a write
    clear_mon();
    push(1'b0, 1'b0, 16'h0AAA, acc);
    push(1'b1, 1'b0, 16'h0BBB, acc);
    wait_wr(1'b0, 20, "mid_wr_seen");
    @(posedge pclk); #1;
    hw_rst_req = 1'b1; tick(1); hw_rst_req = 1'b0;
    wait_idle(300, "midreq");
    chk("midreq_nstrobe", obs_q.size(), 2);
    chk("midreq_npulse", rst_len_q.size(), 1);
    chk("midreq_ncs", cs_runs_q.size(), 2);
    if (obs_q.size() == 2 && rst_start_q.size() > 0) begin
      chk("midreq_first_len", obs_q[0].len, T_LOW);
      chk("midreq_first_data", obs_q[0].data, 16'h0AAA);
      chk("midreq_second_data", obs_q[1].data, 16'h0BBB);
      chk("midreq_after_first", rst_start_q[0] > obs_q[0].start + obs_q[0].len, 1'b1);
      chk("midreq_before_second", rst_start_q[0] + T_RST <= obs_q[1].start, 1'b1);
    end
    if (rst_len_q.size() > 0) chk("midreq_rstlen", rst_len_q[0], T_RST);
    if (cs_runs_q.size() > 0) chk("midreq_cslen", cs_runs_q[0], XFER);

    // ---------------- prst mid-burst, during HOLD
    clear_mon();
    push(1'b1, 1'b0, 16'hC001, acc);
    push(1'b1, 1'b0, 16'hC002, acc);
    push(1'b1, 1'b0, 16'hC003, acc);
    wait_wr(1'b0, 20, "abort_wr_low");
    wait_wr(1'b1, 20, "abort_hold");
    prst = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    chk("abort_cs", cs, 1'b1);
    chk("abort_wr", wr, 1'b1);
    chk("abort_oe", data_oe, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    @(posedge pclk); #1;
    prst = 1'b1;
    clear_mon();
    tick(40);
    chk("abort_no_replay", obs_q.size(), 0);
    chk("abort_no_cs", cs_runs_q.size(), 0);

    // ---------------- randomized traffic against a transaction-level model
    clear_mon();
    for (int i = 0; i < 80; i++) begin
      data_i = 16'($urandom);
      hw_rst_req = ($urandom_range(19, 0) == 0);
      if ($urandom_range(3, 0) != 0) begin
        e.rs = 1'($urandom); e.rd = 1'($urandom); e.data = 16'($urandom);
        push(e.rs, e.rd, e.data, acc);
        if (acc) exp_q.push_back(e);
      end else begin
        tick(1);
      end
      hw_rst_req = 1'b0;
    end
    data_i = 16'h0000;
    tick(T_RST + 4);
    wait_idle(3000, "rand");
    tick(T_RST + 4);
    chk("rand_ntransfers", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("rand%0d_rs", i), obs_q[i].rs, exp_q[i].rs);
      chk($sformatf("rand%0d_dir", i), obs_q[i].rd, exp_q[i].rd);
      chk($sformatf("rand%0d_oe", i), obs_q[i].oe, !exp_q[i].rd);
      chk($sformatf("rand%0d_len", i), obs_q[i].len, T_LOW);
      chk($sformatf("rand%0d_stable", i), obs_q[i].stable, 1'b1);
      if (!exp_q[i].rd) chk($sformatf("rand%0d_data", i), obs_q[i].data, exp_q[i].data);
      else exp_rdv.push_back(obs_q[i].din);
    end
    chk("rand_nrdv", rdv_q.size(), exp_rdv.size());
    for (int i = 0; i < exp_rdv.size() && i < rdv_q.size(); i++)
      chk($sformatf("rand_rdv%0d", i), rdv_q[i], exp_rdv[i]);
    sum = 0; mod_ok = 1'b1;
    foreach (cs_runs_q[i]) begin
      sum += cs_runs_q[i];
      if (cs_runs_q[i] % XFER != 0) mod_ok = 1'b0;
    end
    chk("rand_cs_total", sum, XFER * exp_q.size());
    chk("rand_cs_multiple", mod_ok, 1'b1);
    foreach (rst_len_q[i]) chk($sformatf("rand_rstlen%0d", i), rst_len_q[i], T_RST);

    chk("bus_protocol_violations", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
